// File: rtl/red_pkg.sv
// Shared types, default sizes and saturation limits for the lane-reduction accumulator.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_LANE_W = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_OUT_W  = 16;

    // Signed range limits of a w-bit two's-complement value, widened to 64 bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/red_add_sat.sv
// Combinational acc + a + b with a two-bit guard band, clamped to the OUT_W signed range.
module red_add_sat
    import red_pkg::*;
#(
    parameter int IN_W  = DEF_LANE_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [OUT_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [OUT_W-1:0] sum_o,
    output logic                    sat_o
);

    localparam int SUM_W = OUT_W + 2;
    localparam logic signed [63:0]      MAX64 = sat_max(OUT_W);
    localparam logic signed [63:0]      MIN64 = sat_min(OUT_W);
    localparam logic signed [SUM_W-1:0] MAX_S = MAX64[SUM_W-1:0];
    localparam logic signed [SUM_W-1:0] MIN_S = MIN64[SUM_W-1:0];

    logic signed [SUM_W-1:0] wide;

    // The guard bits make the three-term sum exact, so the clamp never sees a wrapped value.
    assign wide = SUM_W'(acc_i) + SUM_W'(a_i) + SUM_W'(b_i);

    always_comb begin
        sum_o = wide[OUT_W-1:0];
        sat_o = 1'b0;
        if (wide > MAX_S) begin
            sum_o = MAX_S[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (wide < MIN_S) begin
            sum_o = MIN_S[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/red_acc.sv
// Reduces a packed vector of signed lanes two lanes per cycle into a saturating,
// optionally accumulating result presented on a valid/ready output.
module red_acc
    import red_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int LANES  = DEF_LANES,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic                    in_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_sum,
    output logic                    out_sat
);

    localparam int IDX_W = (LANES > 2) ? $clog2(LANES / 2) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES / 2 - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [LANES*LANE_W-1:0]   data_q, data_d;
    logic signed [OUT_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic signed [OUT_W-1:0]   last_sum_q, last_sum_d;
    logic                      last_sat_q, last_sat_d;
    logic signed [OUT_W-1:0]   out_sum_q, out_sum_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [LANE_W-1:0]  lane_a, lane_b;
    logic signed [OUT_W-1:0]   add_sum;
    logic                      add_sat;

    // The captured vector shifts down one pair per step, so the active pair is always the bottom two lanes.
    assign lane_a = data_q[LANE_W-1:0];
    assign lane_b = data_q[2*LANE_W-1:LANE_W];

    red_add_sat #(
        .IN_W  (LANE_W),
        .OUT_W (OUT_W)
    ) u_add (
        .acc_i (acc_q),
        .a_i   (lane_a),
        .b_i   (lane_b),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        last_sum_d = last_sum_q;
        last_sat_d = last_sat_q;
        out_sum_d  = out_sum_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    idx_d   = '0;
                    acc_d   = in_acc ? last_sum_q : '0;
                    sat_d   = in_acc ? last_sat_q : 1'b0;
                    state_d = SUM;
                end
            end
            SUM: begin
                acc_d  = add_sum;
                sat_d  = sat_q | add_sat;
                idx_d  = idx_q + 1'b1;
                data_d = data_q >> (2 * LANE_W);
                if (idx_q == LAST) begin
                    out_sum_d = add_sum;
                    out_sat_d = sat_q | add_sat;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    last_sum_d = acc_q;
                    last_sat_d = sat_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            last_sum_q <= '0;
            last_sat_q <= 1'b0;
            out_sum_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            last_sum_q <= last_sum_d;
            last_sat_q <= last_sat_d;
            out_sum_q  <= out_sum_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_red_acc.sv
// Bench for red_acc: a 16-bit and a 10-bit result instance driven in lockstep.
module tb_red_acc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_acc = 1'b0;
    logic [31:0]        in_data = '0;
    logic               out_ready = 1'b0;
    logic               in_ready16, in_ready10;
    logic               out_valid16, out_valid10;
    logic signed [15:0] sum16;
    logic signed [9:0]  sum10;
    logic               sat16, sat10;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic        acc;
        longint      e16;
        logic        s16;
        longint      e10;
        logic        s10;
    } vec_t;

    typedef struct {
        longint e16;
        logic   s16;
        longint e10;
        logic   s10;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    red_acc #(.LANE_W(8), .LANES(4), .OUT_W(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .in_acc(in_acc), .out_valid(out_valid16),
        .out_ready(out_ready), .out_sum(sum16), .out_sat(sat16)
    );

    red_acc #(.LANE_W(8), .LANES(4), .OUT_W(10)) u10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
        .in_data(in_data), .in_acc(in_acc), .out_valid(out_valid10),
        .out_ready(out_ready), .out_sum(sum10), .out_sat(sat10)
    );

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic longint clampw(input longint v, input int w);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic a, input exp_t e);
        int c = 0;
        while (!in_ready16 && c < 20) begin
            tick();
            c++;
        end
        check("in_ready_wait", longint'(in_ready16), 1);
        in_data  = d;
        in_acc   = a;
        in_valid = 1'b1;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect();
        int   cyc = 0;
        exp_t e;
        while (!out_valid16 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", cyc, 2);
        check("out_valid10", longint'(out_valid10), 1);
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sum16", longint'(sum16), e.e16);
            check("sat16", longint'(sat16), longint'(e.s16));
            check("sum10", longint'(sum10), e.e10);
            check("sat10", longint'(sat10), longint'(e.s10));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released_valid", longint'(out_valid16), 0);
        check("released_ready", longint'(in_ready16 & in_ready10), 1);
    endtask

    initial begin
        longint p16, p10, v16, v10;
        logic   st16, st10;

        tbl[0] = '{pack(1, 2, 3, 4),         1'b0,    10, 1'b0,   10, 1'b0};
        tbl[1] = '{pack(-128, -128, -128, -128), 1'b0, -512, 1'b0, -512, 1'b0};
        tbl[2] = '{pack(127, 127, 127, 127), 1'b0,   508, 1'b0,  508, 1'b0};
        tbl[3] = '{pack(127, 127, 127, 127), 1'b1,  1016, 1'b0,  511, 1'b1};
        tbl[4] = '{pack(0, 0, 0, 0),         1'b1,  1016, 1'b0,  511, 1'b1};
        tbl[5] = '{pack(1, -1, 0, 0),        1'b0,     0, 1'b0,    0, 1'b0};
        tbl[6] = '{pack(-128, -128, -128, -128), 1'b1, -512, 1'b0, -512, 1'b0};
        tbl[7] = '{pack(-128, -128, -128, -128), 1'b1, -1024, 1'b0, -512, 1'b1};
        tbl[8] = '{pack(5, -3, 100, -90),    1'b0,    12, 1'b0,   12, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", longint'(in_ready16), 1);
        check("rst_out_valid", longint'(out_valid16), 0);
        check("rst_sum16", longint'(sum16), 0);
        check("rst_sat16", longint'(sat16), 0);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].data, tbl[i].acc, '{tbl[i].e16, tbl[i].s16, tbl[i].e10, tbl[i].s10});
            collect();
            release_out();
        end

        // Back-pressure in HOLD while new vectors are offered and must be dropped
        send(pack(1, 2, 3, 4), 1'b0, '{10, 1'b0, 10, 1'b0});
        collect();
        for (int k = 0; k < 5; k++) begin
            in_data  = pack(9, 9, 9, 9);
            in_acc   = 1'b0;
            in_valid = 1'b1;
            tick();
            check("hold_sum", longint'(sum16), 10);
            check("hold_valid", longint'(out_valid16), 1);
            check("hold_ready", longint'(in_ready16), 0);
        end
        in_valid = 1'b0;
        release_out();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dropped_valid", longint'(out_valid16), 0);
            check("idle_sum_held", longint'(sum16), 10);
        end

        // Reset in SUM clears last_sum, so a following accumulate starts from zero
        in_data  = pack(10, 10, 10, 10);
        in_acc   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("in_sum_ready", longint'(in_ready16), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", longint'(out_valid16), 0);
        check("midrst_ready", longint'(in_ready16), 1);
        check("midrst_sum", longint'(sum16), 0);
        check("midrst_sat", longint'(sat16), 0);
        send(pack(1, 1, 1, 1), 1'b1, '{4, 1'b0, 4, 1'b0});
        collect();
        release_out();

        // Long accumulation up to the 16-bit positive limit
        p16 = 0; p10 = 0; st16 = 1'b0; st10 = 1'b0;
        for (int i = 0; i < 66; i++) begin
            if (i == 0) begin
                p16 = 0; p10 = 0; st16 = 1'b0; st10 = 1'b0;
            end
            v16 = p16 + 508;
            v10 = p10 + 508;
            p16 = clampw(v16, 16);
            p10 = clampw(v10, 10);
            st16 = st16 | (p16 != v16);
            st10 = st10 | (p10 != v10);
            send(pack(127, 127, 127, 127), (i != 0), '{p16, st16, p10, st10});
            collect();
            release_out();
        end
        check("final_sum16", longint'(sum16), 32767);
        check("final_sat16", longint'(sat16), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/red_acc.md
RED_ACC -- requirements
Module: red_acc

Interface
REQ-001 The block SHALL have parameter LANE_W, default 8: width of each signed input lane.
REQ-002 The block SHALL have parameter LANES, default 4: lane count; even and >=2.
REQ-003 The block SHALL have parameter OUT_W, default 16: signed result width; must be >= LANE_W+1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data and in_acc are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-008 The block SHALL have port in_data, input, LANES*LANE_W bits: packed signed lanes; lane k is in_data[k*LANE_W +: LANE_W].
REQ-009 The block SHALL have port in_acc, input, 1 bit: 1 = add onto the previous result; 0 = start from zero.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_sum and out_sat are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port out_sum, output, OUT_W bits: signed reduction result.
REQ-013 The block SHALL have port out_sat, output, 1 bit: sticky saturation flag for this result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SUM and HOLD.
REQ-015 In IDLE, in_ready SHALL be 1; in SUM and HOLD it SHALL be 0.
REQ-016 On in_valid&in_ready, the block SHALL:
- capture in_data;
- clear the pair index;
- load acc = in_acc ? last_sum : 0;
- load sat = in_acc ? last_sat : 0;
- go to SUM.
REQ-017 In SUM, each cycle SHALL compute acc + sext(lane 2i) + sext(lane 2i+1) for pair index i, saturate it to the OUT_W signed range, and increment i.
REQ-018 If any step saturates, sat SHALL be set and stay set until the next non-accumulating start.
REQ-019 After the add for pair LANES/2-1, the FSM SHALL enter HOLD.
- Latency: LANES/2 cycles from the acceptance edge to out_valid high.
REQ-020 In HOLD:
- out_valid SHALL be 1;
- out_sum SHALL equal acc and out_sat SHALL equal sat;
- both SHALL stay stable until out_valid&out_ready.
REQ-021 On out_valid&out_ready:
- last_sum SHALL take acc and last_sat SHALL take sat;
- the FSM SHALL return to IDLE;
- next acceptance is possible one cycle later.
REQ-022 Outside HOLD, out_valid SHALL be 0 and out_sum SHALL hold the last value presented.
REQ-023 in_valid asserted outside IDLE SHALL be ignored and not queued.
REQ-024 Saturation SHALL clamp to +(2^(OUT_W-1)-1) or -2^(OUT_W-1) and SHALL never wrap.
REQ-025 The internal adder SHALL be OUT_W+2 bits wide so the pre-clamp sum cannot overflow.

Reset
REQ-026 With rst high at a clock edge, from any state:
- state SHALL go to IDLE;
- acc, last_sum and out_sum SHALL be 0;
- sat, last_sat, out_sat and out_valid SHALL be 0;
- in_ready SHALL be 1 on the following cycle.
REQ-027 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-028 Package red_pkg SHALL hold:
- the state enum (IDLE/SUM/HOLD);
- default constants for LANE_W, LANES and OUT_W;
- a saturation-limit function.
REQ-029 The block SHALL use one sub-module, red_add_sat: a combinational, parametrised 3-operand signed add with clamp and saturation flag.
REQ-030 The RTL size target SHALL be 120-400 lines.

Verification (LANES=4, LANE_W=8, OUT_W=16 unless stated)
REQ-031 The bench SHALL apply lanes {1,2,3,4}, in_acc=0 -> out_valid 2 cycles after acceptance, out_sum=10, out_sat=0.
REQ-032 The bench SHALL apply lanes {-128,-128,-128,-128} -> out_sum=-512 (0xFE00), out_sat=0.
REQ-033 The bench SHALL apply {127,127,127,127} with in_acc=0, then the same vector with in_acc=1 -> out_sum 508, then 1016.
REQ-034 With OUT_W=10, the bench SHALL run the same two vectors as REQ-033 -> out_sum 508/out_sat=0, then out_sum 511/out_sat=1.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid -> out_sum stable, in_ready=0, the input is dropped, then normal release.
REQ-036 The bench SHALL assert rst during SUM, then apply {1,1,1,1} with in_acc=1 -> after reset out_valid=0, in_ready=1, and the result is 4, because last_sum was cleared.
